pong_game_ctrl: RTL

//  Match sequencer for Pong: starts/stops the ball datapath via o_Game_Active, detects misses at

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_paddle_hit.sv | 32 +++
 rtl/pong_game_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared board geometry, match state encoding and winner codes
//            for the Pong match sequencer and its helpers.
// Contents : c_GAME_WIDTH, c_GAME_HEIGHT, c_PADDLE_HEIGHT, state_e,
//            c_WINNER_* codes.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Board geometry: P1 goal is column 0, P2 goal is column c_GAME_WIDTH-1.
  localparam int c_GAME_WIDTH    = 40;
  localparam int c_GAME_HEIGHT   = 30;
  localparam int c_PADDLE_HEIGHT = 6;

  // Match sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RUNNING    = 2'd1,
    ST_SERVE_WAIT = 2'd2,
    ST_GAME_OVER  = 2'd3
  } state_e;

  // Winner encoding driven on o_Winner.
  localparam logic [1:0] c_WINNER_NONE = 2'b00;
  localparam logic [1:0] c_WINNER_P1   = 2'b01;
  localparam logic [1:0] c_WINNER_P2   = 2'b10;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/pong_paddle_hit.sv
`default_nettype none
// ============================================================================
// Module   : pong_paddle_hit
// Purpose  : Decides whether a ball row falls within a paddle's span,
//            Paddle_Y .. Paddle_Y + c_PADDLE_HEIGHT - 1.
// Ports    : i_Ball_Y   [5:0] in  ball row
//            i_Paddle_Y [5:0] in  paddle top row
//            o_Hit            out 1 when the ball row is covered by the paddle
// Revision : 1.0 - initial release
// ============================================================================
module pong_paddle_hit
  import pong_pkg::*;
(
  input  logic [5:0] i_Ball_Y,
  input  logic [5:0] i_Paddle_Y,
  output logic       o_Hit
);

  // Evaluated 7 bits wide so a paddle near row 63 does not wrap its bottom
  // edge back to the top of the range.
  logic [6:0] ball_y_ext;
  logic [6:0] paddle_top_ext;
  logic [6:0] paddle_end_ext;

  assign ball_y_ext     = {1'b0, i_Ball_Y};
  assign paddle_top_ext = {1'b0, i_Paddle_Y};
  assign paddle_end_ext = paddle_top_ext + 7'(c_PADDLE_HEIGHT);

  assign o_Hit = (ball_y_ext >= paddle_top_ext) && (ball_y_ext < paddle_end_ext);

endmodule : pong_paddle_hit
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Purpose  : Pong match sequencer. Runs/pauses the ball datapath, detects
//            misses at either goal column, keeps both scores, pauses for a
//            serve after each point and ends the match at the score limit.
// Ports    : i_Clk            in   system clock
//            i_Rst            in   synchronous active-high reset
//            i_Start          in   one-cycle start pulse
//            i_Ball_X   [5:0] in   ball column
//            i_Ball_Y   [5:0] in   ball row
//            i_Paddle_Y_P1[5:0] in left paddle top row
//            i_Paddle_Y_P2[5:0] in right paddle top row
//            o_Game_Active    out  high only while the ball is in play
//            o_P1_Score [3:0] out  P1 points
//            o_P2_Score [3:0] out  P2 points
//            o_Point_P1       out  one-cycle pulse, P1 scored
//            o_Point_P2       out  one-cycle pulse, P2 scored
//            o_Winner   [1:0] out  00 none, 01 P1, 10 P2
// Revision : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int c_SCORE_LIMIT = 9,
  parameter int c_SERVE_DELAY = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic [5:0] i_Ball_X,
  input  logic [5:0] i_Ball_Y,
  input  logic [5:0] i_Paddle_Y_P1,
  input  logic [5:0] i_Paddle_Y_P2,
  output logic       o_Game_Active,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic       o_Point_P1,
  output logic       o_Point_P2,
  output logic [1:0] o_Winner
);

  localparam int               CNT_W      = (c_SERVE_DELAY > 1) ? $clog2(c_SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(c_SERVE_DELAY - 1);
  localparam logic [3:0]       SCORE_LIM  = 4'(c_SCORE_LIMIT);
  localparam logic [5:0]       P2_GOAL_X  = 6'(c_GAME_WIDTH - 1);

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [3:0]       p1_q,     p1_d;
  logic [3:0]       p2_q,     p2_d;
  logic [1:0]       win_q,    win_d;
  logic             active_q, active_d;
  logic             pt1_q,    pt1_d;
  logic             pt2_q,    pt2_d;

  logic hit_p1;
  logic hit_p2;
  logic miss_p1;
  logic miss_p2;
  logic [3:0] p1_next;
  logic [3:0] p2_next;

  pong_paddle_hit u_hit_p1 (
    .i_Ball_Y   (i_Ball_Y),
    .i_Paddle_Y (i_Paddle_Y_P1),
    .o_Hit      (hit_p1)
  );

  pong_paddle_hit u_hit_p2 (
    .i_Ball_Y   (i_Ball_Y),
    .i_Paddle_Y (i_Paddle_Y_P2),
    .o_Hit      (hit_p2)
  );

  // A miss at P1's goal scores for P2 and vice versa.
  assign miss_p1 = (i_Ball_X == 6'd0)      && !hit_p1;
  assign miss_p2 = (i_Ball_X == P2_GOAL_X) && !hit_p2;

  // Saturating increments: a score never moves past the limit.
  assign p1_next = (p1_q < SCORE_LIM) ? p1_q + 4'd1 : p1_q;
  assign p2_next = (p2_q < SCORE_LIM) ? p2_q + 4'd1 : p2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    pt1_d   = 1'b0;
    pt2_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          state_d = ST_RUNNING;
        end
      end

      ST_RUNNING: begin
        if (miss_p1) begin
          p2_d  = p2_next;
          pt2_d = 1'b1;
          if (p2_next == SCORE_LIM) begin
            state_d = ST_GAME_OVER;
            win_d   = c_WINNER_P2;
          end else begin
            state_d = ST_SERVE_WAIT;
            cnt_d   = '0;
          end
        end else if (miss_p2) begin
          p1_d  = p1_next;
          pt1_d = 1'b1;
          if (p1_next == SCORE_LIM) begin
            state_d = ST_GAME_OVER;
            win_d   = c_WINNER_P1;
          end else begin
            state_d = ST_SERVE_WAIT;
            cnt_d   = '0;
          end
        end
      end

      ST_SERVE_WAIT: begin
        // The counter walks 0..c_SERVE_DELAY-1, one value per paused cycle.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUNNING;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAME_OVER: begin
        if (i_Start) begin
          p1_d    = 4'd0;
          p2_d    = 4'd0;
          win_d   = c_WINNER_NONE;
          state_d = ST_SERVE_WAIT;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered from the next state so the output tracks the state exactly.
    active_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      p1_q     <= 4'd0;
      p2_q     <= 4'd0;
      win_q    <= c_WINNER_NONE;
      active_q <= 1'b0;
      pt1_q    <= 1'b0;
      pt2_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      win_q    <= win_d;
      active_q <= active_d;
      pt1_q    <= pt1_d;
      pt2_q    <= pt2_d;
    end
  end

  assign o_Game_Active = active_q;
  assign o_P1_Score    = p1_q;
  assign o_P2_Score    = p2_q;
  assign o_Point_P1    = pt1_q;
  assign o_Point_P2    = pt2_q;
  assign o_Winner      = win_q;

endmodule : pong_game_ctrl
`default_nettype wire
